// File: rtl/parking_lot_ctrl_pkg.sv
// Shared defaults and helpers for the parking lot controller.
package parking_lot_ctrl_pkg;

  localparam int unsigned DEF_N_ZONES   = 4;
  localparam int unsigned DEF_ZONE_CAP  = 10;
  localparam int unsigned DEF_AF_MARGIN = 2;

  // Ceiling log2, elaboration-time only.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/parking_zone_counter.sv
// One parking zone: sensor edge detect, saturating occupancy counter,
// registered status flags and reject/error pulses.
module parking_zone_counter
  import parking_lot_ctrl_pkg::*;
#(
  parameter int unsigned ZONE_CAP  = DEF_ZONE_CAP,
  parameter int unsigned AF_MARGIN = DEF_AF_MARGIN,
  parameter int unsigned CNT_W     = clog2(ZONE_CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in,
  input  logic             car_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             entry_reject,
  output logic             exit_error,
  output logic             inc_c,
  output logic             dec_c
);

  localparam logic [CNT_W-1:0] CAP       = CNT_W'(ZONE_CAP);
  localparam logic             AFULL_RST = (ZONE_CAP <= AF_MARGIN);

  logic             in_prev, out_prev;
  logic             in_evt, out_evt;
  logic             rej_d, err_d;
  logic [CNT_W-1:0] count_d;

  assign in_evt  = car_in  & ~in_prev;
  assign out_evt = car_out & ~out_prev;

  // Simultaneous entry and exit cancel out, even at the boundaries.
  always_comb begin
    inc_c   = 1'b0;
    dec_c   = 1'b0;
    rej_d   = 1'b0;
    err_d   = 1'b0;
    count_d = count;
    if (in_evt && !out_evt) begin
      if (count == CAP) rej_d = 1'b1;
      else              inc_c = 1'b1;
    end else if (out_evt && !in_evt) begin
      if (count == '0) err_d = 1'b1;
      else             dec_c = 1'b1;
    end
    if (inc_c)      count_d = count + CNT_W'(1);
    else if (dec_c) count_d = count - CNT_W'(1);
  end

  // Flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_prev      <= 1'b0;
      out_prev     <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      afull        <= AFULL_RST;
      entry_reject <= 1'b0;
      exit_error   <= 1'b0;
    end else begin
      in_prev      <= car_in;
      out_prev     <= car_out;
      count        <= count_d;
      full         <= (count_d == CAP);
      empty        <= (count_d == '0);
      afull        <= ((ZONE_CAP - 32'(count_d)) <= AF_MARGIN);
      entry_reject <= rej_d;
      exit_error   <= err_d;
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: N independent zone counters plus a running
// lot-wide total and lot full/empty flags.
module parking_lot_ctrl
  import parking_lot_ctrl_pkg::*;
#(
  parameter  int unsigned N_ZONES   = DEF_N_ZONES,
  parameter  int unsigned ZONE_CAP  = DEF_ZONE_CAP,
  parameter  int unsigned AF_MARGIN = DEF_AF_MARGIN,
  localparam int unsigned CNT_W     = clog2(ZONE_CAP + 1),
  localparam int unsigned TOT_W     = clog2(N_ZONES * ZONE_CAP + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_ZONES-1:0]       car_in,
  input  logic [N_ZONES-1:0]       car_out,
  output logic [N_ZONES*CNT_W-1:0] zone_count,
  output logic [N_ZONES-1:0]       zone_full,
  output logic [N_ZONES-1:0]       zone_empty,
  output logic [N_ZONES-1:0]       zone_afull,
  output logic [N_ZONES-1:0]       entry_reject,
  output logic [N_ZONES-1:0]       exit_error,
  output logic [TOT_W-1:0]         total_count,
  output logic                     lot_full,
  output logic                     lot_empty
);

  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(N_ZONES * ZONE_CAP);

  logic [N_ZONES-1:0] inc, dec;
  logic [TOT_W-1:0]   total_d;

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    parking_zone_counter #(
      .ZONE_CAP  (ZONE_CAP),
      .AF_MARGIN (AF_MARGIN),
      .CNT_W     (CNT_W)
    ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .car_in       (car_in[z]),
      .car_out      (car_out[z]),
      .count        (zone_count[z*CNT_W +: CNT_W]),
      .full         (zone_full[z]),
      .empty        (zone_empty[z]),
      .afull        (zone_afull[z]),
      .entry_reject (entry_reject[z]),
      .exit_error   (exit_error[z]),
      .inc_c        (inc[z]),
      .dec_c        (dec[z])
    );
  end

  // Net change this edge: zone increments minus zone decrements.
  always_comb begin
    total_d = total_count;
    for (int z = 0; z < N_ZONES; z++) begin
      if (inc[z]) total_d = total_d + TOT_W'(1);
      if (dec[z]) total_d = total_d - TOT_W'(1);
    end
  end

  // Every zone is capped, so the lot is full exactly when the total hits max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_count <= '0;
      lot_full    <= 1'b0;
      lot_empty   <= 1'b1;
    end else begin
      total_count <= total_d;
      lot_full    <= (total_d == TOT_MAX);
      lot_empty   <= (total_d == '0);
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: driver pushes per-cycle expectations,
// monitor pops and compares after each rising edge.
module tb_parking_lot_ctrl;

  localparam int NZ  = 4;
  localparam int CAP = 10;
  localparam int CW  = 4;

  logic        clk, reset;
  logic [3:0]  car_in, car_out;
  logic [15:0] zone_count;
  logic [3:0]  zone_full, zone_empty, zone_afull, entry_reject, exit_error;
  logic [5:0]  total_count;
  logic        lot_full, lot_empty;

  typedef struct packed {
    logic [15:0] cnt;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  afull;
    logic [3:0]  rej;
    logic [3:0]  err;
    logic [5:0]  tot;
    logic        lf;
    logic        le;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_cnt[NZ];
  logic [3:0] m_pin, m_pout;

  parking_lot_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .car_in       (car_in),
    .car_out      (car_out),
    .zone_count   (zone_count),
    .zone_full    (zone_full),
    .zone_empty   (zone_empty),
    .zone_afull   (zone_afull),
    .entry_reject (entry_reject),
    .exit_error   (exit_error),
    .total_count  (total_count),
    .lot_full     (lot_full),
    .lot_empty    (lot_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) m_cnt[z] = 0;
    m_pin  = '0;
    m_pout = '0;
  endtask

  // Apply one cycle of sensor levels and queue what the next edge must produce.
  task automatic drive(input logic [3:0] ci, input logic [3:0] co, input bit rel);
    exp_t e;
    int   tot;
    @(negedge clk);
    if (rel) reset = 1'b1;
    car_in  = ci;
    car_out = co;
    e   = '0;
    tot = 0;
    for (int z = 0; z < NZ; z++) begin
      bit ie, oe;
      ie = ci[z] & ~m_pin[z];
      oe = co[z] & ~m_pout[z];
      if (ie && !oe) begin
        if (m_cnt[z] == CAP) e.rej[z] = 1'b1;
        else                 m_cnt[z]++;
      end else if (oe && !ie) begin
        if (m_cnt[z] == 0) e.err[z] = 1'b1;
        else               m_cnt[z]--;
      end
      e.cnt[z*CW +: CW] = 4'(m_cnt[z]);
      e.full[z]  = (m_cnt[z] == CAP);
      e.empty[z] = (m_cnt[z] == 0);
      e.afull[z] = ((CAP - m_cnt[z]) <= 2);
      tot += m_cnt[z];
    end
    e.tot = 6'(tot);
    e.lf  = (tot == NZ * CAP);
    e.le  = (tot == 0);
    m_pin  = ci;
    m_pout = co;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("zone_count",   32'(zone_count),   32'(e.cnt));
        chk("zone_full",    32'(zone_full),    32'(e.full));
        chk("zone_empty",   32'(zone_empty),   32'(e.empty));
        chk("zone_afull",   32'(zone_afull),   32'(e.afull));
        chk("entry_reject", 32'(entry_reject), 32'(e.rej));
        chk("exit_error",   32'(exit_error),   32'(e.err));
        chk("total_count",  32'(total_count),  32'(e.tot));
        chk("lot_full",     32'(lot_full),     32'(e.lf));
        chk("lot_empty",    32'(lot_empty),    32'(e.le));
        for (int z = 0; z < NZ; z++)
          chk("count_in_range", 32'(zone_count[z*CW +: CW] <= 4'd10), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    car_in  = '0;
    car_out = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_zone_count",   32'(zone_count),   32'd0);
    chk("rst_total",        32'(total_count),  32'd0);
    chk("rst_zone_empty",   32'(zone_empty),   32'hF);
    chk("rst_zone_full",    32'(zone_full),    32'd0);
    chk("rst_zone_afull",   32'(zone_afull),   32'd0);
    chk("rst_entry_reject", 32'(entry_reject), 32'd0);
    chk("rst_exit_error",   32'(exit_error),   32'd0);
    chk("rst_lot_empty",    32'(lot_empty),    32'd1);
    chk("rst_lot_full",     32'(lot_full),     32'd0);

    // Level held high counts once.
    drive(4'h0, 4'h0, 1'b1);
    repeat (5) drive(4'h1, 4'h0, 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    drain();
    chk("hold_count0", 32'(zone_count[3:0]), 32'd1);
    chk("hold_total",  32'(total_count),     32'd1);

    // Eleven entries into zone 1: saturates at 10 with one reject.
    repeat (11) begin
      drive(4'h2, 4'h0, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
    end
    drain();
    chk("fill_count1", 32'(zone_count[7:4]), 32'd10);
    chk("fill_full1",  32'(zone_full[1]),    32'd1);
    chk("fill_afull1", 32'(zone_afull[1]),   32'd1);

    // Exit from an empty zone 2.
    drive(4'h0, 4'h4, 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    drain();
    chk("underflow_count2", 32'(zone_count[11:8]), 32'd0);
    chk("underflow_empty2", 32'(zone_empty[2]),    32'd1);

    // Simultaneous entry+exit on zone 3 at full, then at empty.
    repeat (10) begin
      drive(4'h8, 4'h0, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
    end
    drive(4'h8, 4'h8, 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    drain();
    chk("simul_full_count3", 32'(zone_count[15:12]), 32'd10);
    repeat (10) begin
      drive(4'h0, 4'h8, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
    end
    drive(4'h8, 4'h8, 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    drain();
    chk("simul_empty_count3", 32'(zone_count[15:12]), 32'd0);

    // Fill the whole lot.
    repeat (10) begin
      drive(4'hF, 4'h0, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
    end
    drain();
    chk("lot_total_40", 32'(total_count), 32'd40);
    chk("lot_full_set", 32'(lot_full),    32'd1);

    // Asynchronous reset between clock edges.
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_zone_count", 32'(zone_count),  32'd0);
    chk("async_total",      32'(total_count), 32'd0);
    chk("async_lot_empty",  32'(lot_empty),   32'd1);
    chk("async_lot_full",   32'(lot_full),    32'd0);
    chk("async_zone_empty", 32'(zone_empty),  32'hF);

    // Sensor already high at reset release registers one event.
    car_in = 4'h1;
    repeat (2) @(posedge clk);
    drive(4'h1, 4'h0, 1'b1);
    drive(4'h0, 4'h0, 1'b0);
    drain();
    chk("release_high_count0", 32'(zone_count[3:0]), 32'd1);

    // Random concurrent traffic on all zones.
    repeat (2000) drive(4'($urandom), 4'($urandom), 1'b0);
    drive(4'h0, 4'h0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
